hh_step_controller: RTL and testbench

Time-step sequencer for the Hodgkin–Huxley neuron datapath. Owns the membrane-potential register `V` and broadcasts it to the ion-current units (Na, K, leak). It pulses their `dt` strobe, waits for their registered outputs to settle, then integrates the summed ionic and external currents into `V`. It runs a requested number of steps per `start`, flags threshold crossings as spikes, and counts them.

---
 rtl/hh_step_controller.sv | 124 ++++++++++++
 tb/tb_hh_step_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hh_step_controller.sv
// Hodgkin-Huxley time-step sequencer: owns V, strobes the current
// units, waits for them to settle, then integrates net current into V.
module hh_step_controller #(
    parameter logic signed [15:0] V_REST        = -16'sd650,
    parameter logic signed [15:0] SPIKE_THRESH  = 16'sd0,
    parameter int unsigned        SETTLE_CYCLES = 3,
    parameter int unsigned        DT_SHIFT      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        step_count,
    input  logic signed [15:0] I_ext,
    input  logic signed [15:0] I_Na,
    input  logic signed [15:0] I_K,
    input  logic signed [15:0] I_L,
    output logic signed [15:0] V,
    output logic               dt,
    output logic               busy,
    output logic               done,
    output logic               spike,
    output logic [7:0]         spike_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DT,
        ST_SETTLE,
        ST_INTEG,
        ST_DONE
    } state_t;

    state_t             state;
    logic [15:0]        remaining;
    logic [3:0]         settle_cnt;
    logic signed [17:0] net;
    logic signed [17:0] dv;
    logic signed [17:0] sum;
    logic signed [15:0] v_next;
    logic [15:0]        rem_dec;
    logic               crossing;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Net current, scaled step and saturated candidate for the next V
    always_comb begin
        net = 18'(I_ext) - 18'(I_Na) - 18'(I_K) - 18'(I_L);
        dv  = net >>> DT_SHIFT;
        sum = 18'(V) + dv;
        if (sum > 18'sd32767) begin
            v_next = 16'sh7fff;
        end else if (sum < -18'sd32768) begin
            v_next = 16'sh8000;
        end else begin
            v_next = sum[15:0];
        end
        crossing = (V < SPIKE_THRESH) && (v_next >= SPIKE_THRESH);
        rem_dec  = remaining - 16'd1;
    end

    assign dt   = (state == ST_DT);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Step sequencer, membrane register and spike bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            V           <= V_REST;
            remaining   <= 16'd0;
            settle_cnt  <= 4'd0;
            spike       <= 1'b0;
            spike_count <= 8'd0;
        end else begin
            spike <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining   <= step_count;
                        spike_count <= 8'd0;
                        if (step_count == 16'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_DT;
                        end
                    end
                end
                ST_DT: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_INTEG;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_INTEG: begin
                    V         <= v_next;
                    remaining <= rem_dec;
                    if (crossing) begin
                        spike <= 1'b1;
                        if (spike_count != 8'd255) begin
                            spike_count <= spike_count + 8'd1;
                        end
                    end
                    if (rem_dec == 16'd0) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hh_step_controller.sv
// Bench for hh_step_controller: directed and random runs checked
// against an arithmetic model of V, spikes and run timing.
module tb_hh_step_controller;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [15:0]        step_count = 16'd0;
    logic signed [15:0] I_ext = 16'sd0;
    logic signed [15:0] I_Na = 16'sd0;
    logic signed [15:0] I_K = 16'sd0;
    logic signed [15:0] I_L = 16'sd0;
    logic signed [15:0] V;
    logic               dt;
    logic               busy;
    logic               done;
    logic               spike;
    logic [7:0]         spike_count;

    int passes = 0;
    int total  = 0;
    int mv     = -650;
    int msc    = 0;

    hh_step_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .step_count  (step_count),
        .I_ext       (I_ext),
        .I_Na        (I_Na),
        .I_K         (I_K),
        .I_L         (I_L),
        .V           (V),
        .dt          (dt),
        .busy        (busy),
        .done        (done),
        .spike       (spike),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        total++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // One integration step of the reference model; returns 1 on a crossing
    function automatic int model_step(input int ext, input int na,
                                      input int k, input int l);
        int net, d, old;
        net = ext - na - k - l;
        if (net >= 0) d = net / 16;
        else d = -((-net + 15) / 16);
        old = mv;
        mv = mv + d;
        if (mv > 32767) mv = 32767;
        if (mv < -32768) mv = -32768;
        return (old < 0 && mv >= 0) ? 1 : 0;
    endfunction

    task automatic run(input string tag, input int n, input int ext,
                       input int na, input int k, input int l,
                       input bit poke);
        int cyc, dts, spk, exp_spk, lat;
        bit acc, seen;
        @(negedge clk);
        I_ext = 16'(ext);
        I_Na = 16'(na);
        I_K = 16'(k);
        I_L = 16'(l);
        step_count = 16'(n);
        start = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            @(posedge clk);
            #1;
            if (busy) acc = 1'b1;
        end
        start = 1'b0;
        check({tag, " accept"}, 32'(acc), 1);
        dts = int'(dt);
        spk = int'(spike);
        seen = done;
        cyc = 0;
        lat = 0;
        while (!seen && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (poke && cyc == 3);
            if (poke && cyc == 3) step_count = 16'(n + 4);
            dts += int'(dt);
            spk += int'(spike);
            if (done) begin
                seen = 1'b1;
                lat = cyc;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 1);
        exp_spk = 0;
        msc = 0;
        for (int s = 0; s < n; s++) begin
            if (model_step(ext, na, k, l) == 1) begin
                exp_spk++;
                if (msc < 255) msc++;
            end
        end
        check({tag, " latency"}, lat, (n == 0) ? 0 : n * 5);
        check({tag, " dt_pulses"}, dts, n);
        check({tag, " spike_pulses"}, spk, exp_spk);
        check({tag, " V"}, 32'(V), mv);
        check({tag, " spike_count"}, 32'(spike_count), msc);
        @(posedge clk);
        #1;
        check({tag, " busy_fall"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst V", 32'(V), -650);
        check("rst busy", 32'(busy), 0);
        check("rst dt", 32'(dt), 0);
        check("rst done", 32'(done), 0);
        check("rst spike_count", 32'(spike_count), 0);
        @(negedge clk);
        rst = 1'b0;

        run("single", 1, 1600, 0, 0, 0, 1'b0);
        check("single V550", 32'(V), -550);

        // Asynchronous abort in the middle of SETTLE
        @(negedge clk);
        step_count = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort V", 32'(V), -650);
        check("abort busy", 32'(busy), 0);
        check("abort dt", 32'(dt), 0);
        check("abort done", 32'(done), 0);
        check("abort spike", 32'(spike), 0);
        @(negedge clk);
        rst = 1'b0;
        mv = -650;
        msc = 0;

        run("cross", 7, 1600, 0, 0, 0, 1'b0);
        check("cross V50", 32'(V), 50);
        check("cross count1", 32'(spike_count), 1);
        run("above", 3, 1600, 0, 0, 0, 1'b0);
        check("above V350", 32'(V), 350);

        run("sat", 6, 32767, -32768, -32768, -32768, 1'b0);
        check("sat V", 32'(V), 32767);
        run("negrnd", 3, -1, 0, 0, 0, 1'b0);
        check("negrnd V", 32'(V), 32764);

        run("zero", 0, 1600, 0, 0, 0, 1'b0);
        run("ignore", 5, -800, 100, -50, 20, 1'b1);
        run("b2b_a", 2, 400, 0, 0, 0, 1'b0);
        run("b2b_b", 2, 400, 0, 0, 0, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mv = -650;
        msc = 0;
        for (int r = 0; r < 12; r++) begin
            run("rand", int'($urandom_range(0, 6)),
                int'($urandom_range(0, 5000)) - 2000,
                int'($urandom_range(0, 1000)) - 500,
                int'($urandom_range(0, 1000)) - 500,
                int'($urandom_range(0, 1000)) - 500, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
